// File: rtl/quad_step_decoder.sv
// ============================================================================
// quad_step_decoder: A/B quadrature decoder with glitch filter, step/dir out.
// Revision: 1.0
// ============================================================================
`default_nettype none

module quad_step_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       a_in,
  input  logic       b_in,
  input  logic       err_clr,
  output logic       step,
  output logic       UpDwn,
  output logic       err,
  output logic [1:0] phase
);

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_TRACK = 1'b1
  } state_t;

  localparam logic [7:0] FLEN = 8'(FILTER_LEN);

  logic [SYNC_STAGES-1:0] sync_a_q, sync_a_d;
  logic [SYNC_STAGES-1:0] sync_b_q, sync_b_d;
  logic [1:0]             sync_ab;
  logic [1:0]             prev_ab_q, prev_ab_d;
  logic [1:0]             phase_q, phase_d;
  logic [7:0]             cnt_q, cnt_d, cnt_inc;
  logic [7:0]             stable_q, stable_d, stable_inc;
  state_t                 state_q, state_d;
  logic                   step_q, step_d;
  logic                   up_dwn_q, up_dwn_d;
  logic                   err_q, err_d;
  logic                   accept;
  logic                   move_up, move_dn, illegal;

  // Successor of a phase when the encoder turns in the "up" direction.
  function automatic logic [1:0] up_next(input logic [1:0] p);
    case (p)
      2'b00:   up_next = 2'b10;
      2'b10:   up_next = 2'b11;
      2'b11:   up_next = 2'b01;
      default: up_next = 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] dn_next(input logic [1:0] p);
    case (p)
      2'b00:   dn_next = 2'b01;
      2'b01:   dn_next = 2'b11;
      2'b11:   dn_next = 2'b10;
      default: dn_next = 2'b00;
    endcase
  endfunction

  always_comb begin
    sync_a_d = {sync_a_q[SYNC_STAGES-2:0], a_in};
    sync_b_d = {sync_b_q[SYNC_STAGES-2:0], b_in};
  end

  assign sync_ab = {sync_a_q[SYNC_STAGES-1], sync_b_q[SYNC_STAGES-1]};

  // A fresh candidate restarts the count with its first cycle already counted,
  // so a change stable for FILTER_LEN synchronized cycles is accepted on time.
  always_comb begin
    prev_ab_d = sync_ab;
    cnt_inc   = (sync_ab != prev_ab_q) ? 8'd1 : cnt_q + 8'd1;
    accept    = (sync_ab != phase_q) && (cnt_inc == FLEN);
    phase_d   = accept ? sync_ab : phase_q;
    if ((sync_ab == phase_q) || accept) begin
      cnt_d = 8'd0;
    end else begin
      cnt_d = cnt_inc;
    end
  end

  always_comb begin
    move_up    = accept && (sync_ab == up_next(phase_q));
    move_dn    = accept && (sync_ab == dn_next(phase_q));
    illegal    = accept && ((sync_ab ^ phase_q) == 2'b11);
    stable_inc = stable_q + 8'd1;
  end

  always_comb begin
    state_d  = state_q;
    stable_d = 8'd0;
    step_d   = 1'b0;
    up_dwn_d = up_dwn_q;
    // Set has priority over clear when both land on the same edge.
    err_d    = err_clr ? 1'b0 : err_q;
    if (state_q == ST_INIT) begin
      if (accept) begin
        state_d = ST_TRACK;
      end else if (sync_ab == phase_q) begin
        if (stable_inc == FLEN) begin
          state_d = ST_TRACK;
        end else begin
          stable_d = stable_inc;
        end
      end
    end else begin
      if (move_up) begin
        step_d   = 1'b1;
        up_dwn_d = 1'b1;
      end else if (move_dn) begin
        step_d   = 1'b1;
        up_dwn_d = 1'b0;
      end else if (illegal) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a_q  <= '0;
      sync_b_q  <= '0;
      prev_ab_q <= 2'b00;
      phase_q   <= 2'b00;
      cnt_q     <= 8'd0;
      stable_q  <= 8'd0;
      state_q   <= ST_INIT;
      step_q    <= 1'b0;
      up_dwn_q  <= 1'b1;
      err_q     <= 1'b0;
    end else begin
      sync_a_q  <= sync_a_d;
      sync_b_q  <= sync_b_d;
      prev_ab_q <= prev_ab_d;
      phase_q   <= phase_d;
      cnt_q     <= cnt_d;
      stable_q  <= stable_d;
      state_q   <= state_d;
      step_q    <= step_d;
      up_dwn_q  <= up_dwn_d;
      err_q     <= err_d;
    end
  end

  assign step  = step_q;
  assign UpDwn = up_dwn_q;
  assign err   = err_q;
  assign phase = phase_q;

endmodule

`default_nettype wire

// File: tb/tb_quad_step_decoder.sv
// Bench for quad_step_decoder: run-length reference model plus directed checks.
`default_nettype none

module tb_quad_step_decoder;

  localparam int SYNC_STAGES = 2;
  localparam int FILTER_LEN  = 4;

  logic       clk;
  logic       rst_n;
  logic       a_in;
  logic       b_in;
  logic       err_clr;
  logic       step;
  logic       UpDwn;
  logic       err;
  logic [1:0] phase;

  int total = 0;
  int bad   = 0;
  int dut_steps = 0;

  quad_step_decoder #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .a_in   (a_in),
    .b_in   (b_in),
    .err_clr(err_clr),
    .step   (step),
    .UpDwn  (UpDwn),
    .err    (err),
    .phase  (phase)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: position on the Gray circle, run-length filtering of the
  // input delayed by SYNC_STAGES samples.
  function automatic int gpos(input logic [1:0] v);
    case (v)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  logic [1:0] raw_q[$];
  logic [1:0] sv_q[$];
  logic [1:0] m_phase;
  logic       m_step, m_ud, m_err, m_track;
  int         m_stable;
  logic [1:0] m_sv;
  int         m_run;
  int         m_dist;
  logic       m_acc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw_q.delete();
      sv_q.delete();
      m_phase  = 2'b00;
      m_step   = 1'b0;
      m_ud     = 1'b1;
      m_err    = 1'b0;
      m_track  = 1'b0;
      m_stable = 0;
    end else begin
      raw_q.push_back({a_in, b_in});
      if (raw_q.size() > SYNC_STAGES + 1) void'(raw_q.pop_front());
      m_sv = (raw_q.size() > SYNC_STAGES) ? raw_q[0] : 2'b00;
      sv_q.push_back(m_sv);
      if (sv_q.size() > 300) void'(sv_q.pop_front());
      m_run = 0;
      for (int i = sv_q.size() - 1; i >= 0; i--) begin
        if (sv_q[i] != m_sv) break;
        m_run++;
      end
      m_acc  = (m_sv != m_phase) && (m_run == FILTER_LEN);
      m_step = 1'b0;
      if (err_clr) m_err = 1'b0;
      if (!m_track) begin
        if (m_acc) begin
          m_phase = m_sv;
          m_track = 1'b1;
        end else if (m_sv == m_phase) begin
          m_stable++;
          if (m_stable == FILTER_LEN) m_track = 1'b1;
        end else begin
          m_stable = 0;
        end
      end else if (m_acc) begin
        m_dist = (gpos(m_sv) - gpos(m_phase) + 4) % 4;
        if (m_dist == 1) begin
          m_step = 1'b1;
          m_ud   = 1'b1;
        end else if (m_dist == 3) begin
          m_step = 1'b1;
          m_ud   = 1'b0;
        end else begin
          m_err = 1'b1;
        end
        m_phase = m_sv;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("model_step",  step,  m_step);
      check("model_updwn", UpDwn, m_ud);
      check("model_err",   err,   m_err);
      check("model_phase", phase, m_phase);
    end
  end

  always @(posedge clk) begin
    if (rst_n === 1'b1 && step === 1'b1) dut_steps++;
  end

  task automatic hold(input logic [1:0] ab, input int n);
    a_in = ab[1];
    b_in = ab[0];
    repeat (n) @(negedge clk);
  endtask

  task automatic hold_lat(input logic [1:0] ab, input int n, output int lat);
    a_in = ab[1];
    b_in = ab[0];
    lat  = -1;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (step === 1'b1 && lat < 0) lat = i;
    end
  endtask

  int s0;
  int lat;

  initial begin
    rst_n   = 1'b0;
    a_in    = 1'b1;
    b_in    = 1'b1;
    err_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_step",  step,  0);
    check("rst_updwn", UpDwn, 1);
    check("rst_err",   err,   0);
    check("rst_phase", phase, 0);

    // INIT absorbs the first accept (00 -> 11) silently
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("init_phase_edge5", phase, 2'b00);
    @(negedge clk);
    check("init_phase_edge6", phase, 2'b11);
    repeat (4) @(negedge clk);
    check("init_no_step", dut_steps, 0);
    check("init_updwn",   UpDwn, 1);
    check("init_err",     err,   0);

    hold(2'b01, 10);
    hold(2'b00, 10);
    check("to_zero_phase", phase, 2'b00);

    // up sequence
    s0 = dut_steps;
    hold_lat(2'b10, 10, lat);
    check("up_latency", lat, 6);
    hold(2'b11, 10);
    hold(2'b01, 10);
    hold(2'b00, 10);
    check("up_steps", dut_steps - s0, 4);
    check("up_updwn", UpDwn, 1);
    check("up_phase", phase, 2'b00);

    // down sequence then reverse
    s0 = dut_steps;
    hold(2'b01, 10);
    hold(2'b11, 10);
    hold(2'b10, 10);
    check("down_steps", dut_steps - s0, 3);
    check("down_updwn", UpDwn, 0);
    hold(2'b11, 10);
    check("rev_steps", dut_steps - s0, 4);
    check("rev_updwn", UpDwn, 1);
    check("rev_phase", phase, 2'b11);

    hold(2'b01, 10);
    hold(2'b00, 10);

    // glitch rejection
    s0 = dut_steps;
    hold(2'b10, 3);
    hold(2'b00, 10);
    check("glitch_steps", dut_steps - s0, 0);
    check("glitch_phase", phase, 2'b00);
    s0 = dut_steps;
    hold(2'b10, 4);
    hold(2'b00, 3);
    check("pulse4_steps", dut_steps - s0, 1);
    check("pulse4_phase", phase, 2'b10);
    hold(2'b00, 10);
    check("pulse4_back_phase", phase, 2'b00);
    check("pulse4_back_updwn", UpDwn, 0);

    // illegal jump
    s0 = dut_steps;
    hold(2'b11, 10);
    check("illegal_err",   err,   1);
    check("illegal_steps", dut_steps - s0, 0);
    check("illegal_phase", phase, 2'b11);
    check("illegal_updwn", UpDwn, 0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("err_clr", err, 0);

    // illegal accept coincides with err_clr: set wins
    hold(2'b00, 5);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("set_wins_err",   err,   1);
    check("set_wins_phase", phase, 2'b00);
    repeat (4) @(negedge clk);

    // asynchronous reset mid-sequence at phase 11
    hold(2'b01, 10);
    hold(2'b11, 10);
    check("pre_rst_phase", phase, 2'b11);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_step",  step,  0);
    check("async_rst_updwn", UpDwn, 1);
    check("async_rst_err",   err,   0);
    check("async_rst_phase", phase, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    s0 = dut_steps;
    repeat (10) @(negedge clk);
    check("rerst_no_step", dut_steps - s0, 0);
    check("rerst_phase",   phase, 2'b11);
    hold(2'b01, 10);
    check("rerst_track_step",  dut_steps - s0, 1);
    check("rerst_track_updwn", UpDwn, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
